// File: rtl/sqrt_datapath_if.sv
// rtl/sqrt_datapath_if.sv - controller/datapath enable interface for the square-root unit
interface sqrt_datapath_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]   din;
    logic               en_a;
    logic               en_del;
    logic               en_sq;
    logic               en_out;
    logic               ld_add;
    logic               greater;
    logic [WIDTH/2-1:0] dout;
    logic               valid;

    modport master (
        output din, en_a, en_del, en_sq, en_out, ld_add,
        input  greater, dout, valid
    );

    modport slave (
        input  din, en_a, en_del, en_sq, en_out, ld_add,
        output greater, dout, valid
    );
endinterface

// File: rtl/sqrt_datapath.sv
// rtl/sqrt_datapath.sv - integer square-root datapath summing successive odd numbers
module sqrt_datapath #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         clr,
    sqrt_datapath_if.slave bus
);
    localparam int HW = WIDTH / 2;
    localparam int DW = HW + 2;

    // SQ tracks (k+1)^2 and DEL tracks 2k+3 after k adds; SQ reaches 2^WIDTH at most
    logic [WIDTH-1:0] a;
    logic [WIDTH:0]   sq;
    logic [DW-1:0]    del;
    logic             load_any;

    assign bus.greater = sq > {1'b0, a};
    assign load_any    = !bus.ld_add && (bus.en_a || bus.en_sq || bus.en_del);

    // Operand register: loaded on a load cycle, held during accumulation
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            a <= '0;
        else if (bus.en_a && !bus.ld_add)
            a <= bus.din;
    end

    // Running square: saturates once it exceeds A so late add cycles are harmless
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            sq <= (WIDTH+1)'(1);
        else if (bus.en_sq) begin
            if (!bus.ld_add)
                sq <= (WIDTH+1)'(1);
            else if (!bus.greater)
                sq <= sq + (WIDTH+1)'(del);
        end
    end

    // Odd increment: steps by two alongside SQ and freezes with it
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            del <= DW'(3);
        else if (bus.en_del) begin
            if (!bus.ld_add)
                del <= DW'(3);
            else if (!bus.greater)
                del <= del + DW'(2);
        end
    end

    // Result register: root is (DEL>>1)-1, taken from the pre-edge DEL
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            bus.dout <= '0;
        else if (bus.en_out)
            bus.dout <= del[HW:1] - HW'(1);
    end

    // Valid flag: a new load invalidates the result, and wins over en_out
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            bus.valid <= 1'b0;
        else if (load_any)
            bus.valid <= 1'b0;
        else if (bus.en_out)
            bus.valid <= 1'b1;
    end
endmodule

// File: tb/tb_sqrt_datapath.sv
// tb/tb_sqrt_datapath.sv - directed self-checking bench for sqrt_datapath
module tb_sqrt_datapath;
    localparam int WIDTH = 8;

    logic clk;
    logic clr;
    int   n_checks;
    int   n_errors;
    int   n_adds;

    sqrt_datapath_if #(.WIDTH(WIDTH)) bus ();

    sqrt_datapath #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.en_a   = 1'b0;
        bus.en_del = 1'b0;
        bus.en_sq  = 1'b0;
        bus.en_out = 1'b0;
        bus.ld_add = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [WIDTH-1:0] d);
        bus.din    = d;
        bus.en_a   = 1'b1;
        bus.en_sq  = 1'b1;
        bus.en_del = 1'b1;
        bus.ld_add = 1'b0;
        tick();
        idle();
    endtask

    task automatic do_add();
        bus.en_a   = 1'b1;
        bus.en_sq  = 1'b1;
        bus.en_del = 1'b1;
        bus.ld_add = 1'b1;
        bus.din    = 8'hA5;
        tick();
        idle();
    endtask

    task automatic run_adds(output int n);
        n = 0;
        while (!bus.greater && n < 40) begin
            do_add();
            n++;
        end
    endtask

    task automatic do_out();
        bus.en_out = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        bus.din  = '0;
        idle();
        clr = 1'b1;
        tick();
        tick();
        // After reset SQ=1, A=0, so greater = (1 > 0) = 1
        check("rst_greater", 32'(bus.greater), 1);
        check("rst_valid", 32'(bus.valid), 0);
        check("rst_dout", 32'(bus.dout), 0);
        check("rst_sq", 32'(dut.sq), 1);
        check("rst_del", 32'(dut.del), 3);
        check("rst_a", 32'(dut.a), 0);
        clr = 1'b0;
        tick();

        // din=9: SQ 1->4->9->16, three adds
        do_load(8'd9);
        check("d9_greater_after_load", 32'(bus.greater), 0);
        run_adds(n_adds);
        check("d9_adds", n_adds, 3);
        do_add();
        check("d9_sq_saturated", 32'(dut.sq), 16);
        check("d9_del_saturated", 32'(dut.del), 9);
        check("d9_a_held", 32'(dut.a), 9);
        do_out();
        check("d9_dout", 32'(bus.dout), 3);
        check("d9_valid", 32'(bus.valid), 1);

        // din=0: greater right after load, adds ignored
        do_load(8'd0);
        check("d0_valid_cleared", 32'(bus.valid), 0);
        check("d0_greater", 32'(bus.greater), 1);
        do_add();
        do_add();
        check("d0_sq_held", 32'(dut.sq), 1);
        check("d0_del_held", 32'(dut.del), 3);
        do_out();
        check("d0_dout", 32'(bus.dout), 0);
        check("d0_valid", 32'(bus.valid), 1);

        // din=255: 15 adds, SQ=256 needs the ninth bit
        do_load(8'd255);
        run_adds(n_adds);
        check("d255_adds", n_adds, 15);
        check("d255_sq", 32'(dut.sq), 256);
        check("d255_del", 32'(dut.del), 33);
        do_out();
        check("d255_dout", 32'(bus.dout), 15);

        // din=15 then reload din=16
        do_load(8'd15);
        run_adds(n_adds);
        check("d15_adds", n_adds, 3);
        check("d15_sq", 32'(dut.sq), 16);
        do_out();
        check("d15_dout", 32'(bus.dout), 3);
        do_load(8'd16);
        check("d16_valid_cleared", 32'(bus.valid), 0);
        run_adds(n_adds);
        check("d16_adds", n_adds, 4);
        do_out();
        check("d16_dout", 32'(bus.dout), 4);
        check("d16_valid", 32'(bus.valid), 1);

        // All enables low: everything holds
        tick();
        tick();
        tick();
        check("hold_dout", 32'(bus.dout), 4);
        check("hold_valid", 32'(bus.valid), 1);
        check("hold_sq", 32'(dut.sq), 25);

        // din=200, five adds leave SQ=36 DEL=13, then asynchronous clear mid-cycle
        do_load(8'd200);
        for (int i = 0; i < 5; i++) do_add();
        check("d200_sq_5adds", 32'(dut.sq), 36);
        check("d200_del_5adds", 32'(dut.del), 13);
        #2;
        clr = 1'b1;
        #1;
        check("clr_async_valid", 32'(bus.valid), 0);
        check("clr_async_sq", 32'(dut.sq), 1);
        check("clr_async_del", 32'(dut.del), 3);
        check("clr_async_dout", 32'(bus.dout), 0);
        tick();
        clr = 1'b0;
        do_load(8'd200);
        run_adds(n_adds);
        check("d200_adds", n_adds, 14);
        do_out();
        check("d200_dout", 32'(bus.dout), 14);
        check("d200_valid", 32'(bus.valid), 1);

        // Load together with en_out: dout from pre-edge DEL=31, load clear wins on valid
        bus.din    = 8'd4;
        bus.en_a   = 1'b1;
        bus.en_sq  = 1'b1;
        bus.en_del = 1'b1;
        bus.en_out = 1'b1;
        bus.ld_add = 1'b0;
        tick();
        idle();
        check("simul_dout", 32'(bus.dout), 14);
        check("simul_valid", 32'(bus.valid), 0);
        check("simul_del", 32'(dut.del), 3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
